// File: rtl/mct_nch.sv
// rtl/mct_nch.sv - NCH-channel arbiter serialising requests onto a byte-wide RAM port.
// Define MCT_RR_EN for round-robin arbitration; fixed priority (channel 0 first) otherwise.
module mct_nch #(
  parameter int NCH   = 2,
  parameter int NBYTE = 4,
  parameter int LW    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NCH-1:0]          req_e,
  input  logic [NCH-1:0]          req_wr,
  input  logic [32*NCH-1:0]       req_a,
  input  logic [8*NBYTE*NCH-1:0]  req_n,
  input  logic [LW*NCH-1:0]       req_len,
  output logic [NCH-1:0]          ok,
  output logic [8*NBYTE-1:0]      rd_n,
  output logic                    busy,
  input  logic [7:0]              ram_in,
  output logic [7:0]              ram_out,
  output logic [31:0]             ram_a,
  output logic                    ram_wr
);

  localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW = $clog2(NBYTE + 1);
  localparam int DW = 8 * NBYTE;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  state_t          r_state, w_next;
  logic [GW-1:0]   r_grant, w_sel;
  logic [CW-1:0]   r_cnt, r_last, w_last;
  logic [31:0]     r_a;
  logic [DW-1:0]   r_data, r_buf;
  logic [LW-1:0]   w_len;
  logic            w_any;

`ifdef MCT_RR_EN
  logic [GW-1:0]   r_ptr;
  logic            w_found;
`endif

  assign w_any = |req_e;

  always_comb begin
    w_sel = '0;
`ifdef MCT_RR_EN
    w_found = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (!w_found && req_e[(int'(r_ptr) + k) % NCH]) begin
        w_sel   = GW'((int'(r_ptr) + k) % NCH);
        w_found = 1'b1;
      end
    end
`else
    for (int k = NCH - 1; k >= 0; k--) begin
      if (req_e[k]) w_sel = GW'(k);
    end
`endif
  end

  // r_last holds N-1, clamped to the widest access the data path supports
  assign w_len  = req_len[LW*int'(w_sel) +: LW];
  assign w_last = (w_len > LW'(NBYTE - 1)) ? CW'(NBYTE - 1) : CW'(w_len);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_any) w_next = req_wr[w_sel] ? S_WR : S_RD;
      S_RD: begin
        if (!req_e[r_grant])                 w_next = S_IDLE;
        else if (r_cnt == r_last + 1'b1)     w_next = S_DONE;
      end
      S_WR:   if (r_cnt == r_last) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_cnt   <= '0;
      r_last  <= '0;
      r_a     <= '0;
      r_data  <= '0;
      r_buf   <= '0;
`ifdef MCT_RR_EN
      r_ptr   <= '0;
`endif
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant <= w_sel;
            r_a     <= req_a[32*int'(w_sel) +: 32];
            r_data  <= req_n[DW*int'(w_sel) +: DW];
            r_last  <= w_last;
            r_cnt   <= '0;
            r_buf   <= '0;
          end
        end
        S_RD: begin
          // RAM data lags the address by one cycle, so beat cnt returns byte cnt-1
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt != '0) r_buf[8*(int'(r_cnt) - 1) +: 8] <= ram_in;
        end
        S_WR: r_cnt <= r_cnt + 1'b1;
        S_DONE: begin
`ifdef MCT_RR_EN
          r_ptr <= (int'(r_grant) == NCH - 1) ? '0 : r_grant + 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign ok      = (r_state == S_DONE) ? (NCH'(1) << r_grant) : '0;
  assign rd_n    = (r_state == S_DONE) ? r_buf : '0;
  assign ram_wr  = (r_state == S_WR);
  assign ram_out = (r_state == S_WR) ? r_data[8*int'(r_cnt) +: 8] : 8'h00;
  assign ram_a   = ((r_state == S_WR) || (r_state == S_RD && r_cnt <= r_last))
                   ? r_a + 32'(r_cnt) : 32'h0;

endmodule

// File: tb/tb_mct_nch.sv
// tb/tb_mct_nch.sv - self-checking bench for mct_nch with a behavioural RAM and reference model.
module tb_mct_nch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_e = '0;
  logic [1:0]  req_wr = '0;
  logic [63:0] req_a = '0;
  logic [63:0] req_n = '0;
  logic [3:0]  req_len = '0;
  logic [1:0]  ok;
  logic [31:0] rd_n;
  logic        busy;
  logic [7:0]  ram_in = 8'h00;
  logic [7:0]  ram_out;
  logic [31:0] ram_a;
  logic        ram_wr;

  int total = 0;
  int bad = 0;
  int mdl_p = 0;

  logic [7:0] ram [logic [31:0]];
  logic [7:0] mdl [logic [31:0]];

  mct_nch dut (
    .clk(clk), .rst_n(rst_n), .req_e(req_e), .req_wr(req_wr), .req_a(req_a),
    .req_n(req_n), .req_len(req_len), .ok(ok), .rd_n(rd_n), .busy(busy),
    .ram_in(ram_in), .ram_out(ram_out), .ram_a(ram_a), .ram_wr(ram_wr)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] dflt(input logic [31:0] ad);
    return ad[7:0] ^ ad[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] ad);
    if (ram.exists(ad)) return ram[ad];
    return dflt(ad);
  endfunction

  function automatic logic [7:0] mdl_rd(input logic [31:0] ad);
    if (mdl.exists(ad)) return mdl[ad];
    return dflt(ad);
  endfunction

  always @(posedge clk) begin
    ram_in <= ram_rd(ram_a);
    if (ram_wr === 1'b1) ram[ram_a] = ram_out;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [31:0] ad, input logic [7:0] v);
    ram[ad] = v;
    mdl[ad] = v;
  endtask

  function automatic int exp_grant(input logic [1:0] r);
`ifdef MCT_RR_EN
    for (int k = 0; k < 2; k++) if (r[(mdl_p + k) % 2]) return (mdl_p + k) % 2;
`else
    for (int k = 0; k < 2; k++) if (r[k]) return k;
`endif
    return -1;
  endfunction

  task automatic set_req(input int ch, input bit wr, input logic [31:0] a,
                         input int len, input logic [31:0] data);
    req_e = '0;
    req_e[ch] = 1'b1;
    req_wr[ch] = wr;
    req_a[32*ch +: 32] = a;
    req_n[32*ch +: 32] = data;
    req_len[2*ch +: 2] = len[1:0];
  endtask

  // Called #1 after a posedge with the controller idle; returns one cycle after ok.
  task automatic run_txn(input string nm, input int ch, input bit wr, input logic [31:0] a,
                         input int len, input logic [31:0] data, input logic [31:0] exp);
    int n = len + 1;
    int lat = wr ? n + 1 : n + 2;
    int cyc = 1;
    bit seen = 0;
    logic [31:0] ea;
    set_req(ch, wr, a, len, data);
    @(posedge clk); #1;
    while (!seen && cyc <= 20) begin
      if (cyc <= n) begin
        ea = a + cyc - 1;
        chk({nm, " ram_a"}, ram_a, ea);
        chk({nm, " ram_wr"}, ram_wr, wr);
        if (wr) chk({nm, " ram_out"}, ram_out, data[8*(cyc-1) +: 8]);
      end
      if (ok != 2'b00) begin
        seen = 1;
        chk({nm, " latency"}, cyc, lat);
        chk({nm, " ok"}, ok, 2'b01 << ch);
        chk({nm, " rd_n"}, rd_n, exp);
        req_e[ch] = 1'b0;
        mdl_p = (ch + 1) % 2;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (!seen) chk({nm, " ok timeout"}, 0, 1);
    if (wr) for (int i = 0; i < n; i++) begin
      ea = a + i;
      mdl[ea] = data[8*i +: 8];
    end
    req_e = '0;
  endtask

  typedef struct {
    int          ch;
    bit          wr;
    logic [31:0] a;
    int          len;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int beats, oks, wrs, ng, pend, g;
    logic [31:0] a, d, ex, ea;
    int len, ch;
    bit wr;

    tbl[0] = '{1, 1'b0, 32'h0000_0100, 3, 32'h0,          32'h4433_2211};
    tbl[1] = '{0, 1'b1, 32'h0000_0020, 1, 32'h0000_BEEF,  32'h0};
    tbl[2] = '{0, 1'b0, 32'h0000_0020, 1, 32'h0,          32'h0000_BEEF};
    tbl[3] = '{0, 1'b0, 32'hFFFF_FFFF, 1, 32'h0,          32'h0000_55AA};
    tbl[4] = '{1, 1'b1, 32'h0000_0200, 0, 32'h1234_5678,  32'h0};
    tbl[5] = '{1, 1'b0, 32'h0000_01FF, 2, 32'h0,          32'h0077_7899};

    preload(32'h100, 8'h11); preload(32'h101, 8'h22);
    preload(32'h102, 8'h33); preload(32'h103, 8'h44);
    preload(32'hFFFF_FFFF, 8'hAA); preload(32'h0, 8'h55);
    preload(32'h1FF, 8'h99); preload(32'h201, 8'h77);

    repeat (2) @(posedge clk);
    #1;
    chk("reset ok", ok, 0);
    chk("reset busy", busy, 0);
    chk("reset rd_n", rd_n, 0);
    chk("reset ram_a", ram_a, 0);
    chk("reset ram_wr", ram_wr, 0);
    chk("reset ram_out", ram_out, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++)
      run_txn($sformatf("vec%0d", i), tbl[i].ch, tbl[i].wr, tbl[i].a,
              tbl[i].len, tbl[i].data, tbl[i].exp);

    // write aborted mid-burst must still complete all four beats
    d = 32'hC0DE_F00D;
    set_req(0, 1'b1, 32'h400, 3, d);
    beats = 0; oks = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (ram_wr) beats++;
      if (ok != 0) oks++;
      if (c == 2) req_e = '0;
    end
    chk("abort wr beats", beats, 4);
    chk("abort wr oks", oks, 1);
    for (int i = 0; i < 4; i++) mdl[32'h400 + i] = d[8*i +: 8];
    mdl_p = 1;
    run_txn("abort wr readback", 1, 1'b0, 32'h400, 3, 32'h0, d);

    // aborted read: no ok, idle next cycle, pointer untouched
    set_req(1, 1'b0, 32'h100, 3, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    req_e = '0;
    @(posedge clk); #1;
    chk("abort rd busy", busy, 0);
    oks = 0; wrs = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (ok != 0) oks++;
      if (ram_wr) wrs++;
    end
    chk("abort rd oks", oks, 0);
    chk("abort rd ram_wr", wrs, 0);

    // contention: both channels re-request right after their ok
    req_wr = '0; req_len = '0;
    req_a = {32'h500, 32'h600};
    req_e = 2'b11;
    ng = 0; pend = -1;
    for (int c = 0; c < 100 && ng < 4; c++) begin
      @(posedge clk); #1;
      if (pend >= 0) begin
        req_e[pend] = 1'b1;
        pend = -1;
      end
      if (ok != 0) begin
        g = ok[1] ? 1 : 0;
        chk($sformatf("grant%0d", ng), g, exp_grant(2'b11));
        mdl_p = (g + 1) % 2;
        req_e[g] = 1'b0;
        pend = g;
        ng++;
      end
    end
    chk("contention grants", ng, 4);
    req_e = '0;
    @(posedge clk); #1;

    for (int t = 0; t < 40; t++) begin
      ch  = $urandom_range(0, 1);
      wr  = 1'($urandom_range(0, 1));
      a   = 32'h300 + $urandom_range(0, 12);
      len = $urandom_range(0, 3);
      d   = $urandom;
      ex  = '0;
      if (!wr) for (int i = 0; i <= len; i++) begin
        ea = a + i;
        ex[8*i +: 8] = mdl_rd(ea);
      end
      run_txn($sformatf("rnd%0d", t), ch, wr, a, len, d, ex);
    end

    // asynchronous reset during a read
    set_req(0, 1'b0, 32'h100, 3, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    req_e = '0;
    #1;
    chk("midrd ok", ok, 0);
    chk("midrd busy", busy, 0);
    chk("midrd ram_a", ram_a, 0);
    chk("midrd ram_wr", ram_wr, 0);
    chk("midrd ram_out", ram_out, 0);
    chk("midrd rd_n", rd_n, 0);
    mdl_p = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    oks = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (ok != 0) oks++;
    end
    chk("midrd no ok", oks, 0);
    chk("midrd idle", busy, 0);
    run_txn("post reset rd", 1, 1'b0, 32'h100, 3, 32'h0, 32'h4433_2211);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
